fft_but_loader: RTL

Input-side loader for the radix-4 complex butterfly `fft_but_comp`. It accepts a serial stream of complex samples under a valid/ready handshake and assembles each run of 4 consecutive samples into one parallel 4-point group. It holds the group on the `X0..X3` outputs until the downstream stage accepts it. Two internal group banks (ping-pong) let the next group fill while the previous one waits, which sustains one sample per clock.

---
 rtl/fft_but_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fft_but_loader.sv
// fft_but_loader
// Input-side loader for the radix-4 butterfly. Collects a serial stream of
// complex samples into 4-sample groups held in two ping-pong banks, so one
// group can fill while the other waits for the downstream stage.
//
// Parameters:
//   BIT    - signed sample width (RE and IM)
//   GROUPS - groups per frame; sets the wrap point of the group counter (>= 2)
//
// Ports:
//   iCLK, iRESET          - clock (rising edge), synchronous active-high reset
//   iVALID, iRE, iIM      - input sample and its valid
//   oREADY                - loader can accept a sample this cycle
//   oX0_RE .. oX3_IM      - assembled group presented to the butterfly
//   oVALID, iREADY        - output group valid / downstream accepts
//   oLAST                 - presented group is the last one of the frame
//
// Configuration:
//   FFT_LOAD_DIGIT_REV_EN - when defined, slot->output mapping is digit
//                           reversed (0->X0, 1->X2, 2->X1, 3->X3);
//                           otherwise slot k drives Xk.

module fft_but_loader #(
  parameter int unsigned BIT    = 17,
  parameter int unsigned GROUPS = 64
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iVALID,
  input  logic signed [BIT-1:0] iRE,
  input  logic signed [BIT-1:0] iIM,
  output logic                  oREADY,
  output logic signed [BIT-1:0] oX0_RE,
  output logic signed [BIT-1:0] oX0_IM,
  output logic signed [BIT-1:0] oX1_RE,
  output logic signed [BIT-1:0] oX1_IM,
  output logic signed [BIT-1:0] oX2_RE,
  output logic signed [BIT-1:0] oX2_IM,
  output logic signed [BIT-1:0] oX3_RE,
  output logic signed [BIT-1:0] oX3_IM,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic                  oLAST
);

  localparam int unsigned GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LAST_G  = GW'(GROUPS - 1);
  localparam logic [1:0]    SLOT_MAX = 2'd3;

  // Storage slot feeding each output position
`ifdef FFT_LOAD_DIGIT_REV_EN
  localparam logic [1:0] SLOT_X0 = 2'd0;
  localparam logic [1:0] SLOT_X1 = 2'd2;
  localparam logic [1:0] SLOT_X2 = 2'd1;
  localparam logic [1:0] SLOT_X3 = 2'd3;
`else
  localparam logic [1:0] SLOT_X0 = 2'd0;
  localparam logic [1:0] SLOT_X1 = 2'd1;
  localparam logic [1:0] SLOT_X2 = 2'd2;
  localparam logic [1:0] SLOT_X3 = 2'd3;
`endif

  logic signed [BIT-1:0] re_q [2][4];
  logic signed [BIT-1:0] im_q [2][4];
  logic [1:0]            full_q;
  logic [1:0]            full_d;
  logic                  wp_q;
  logic                  rp_q;
  logic [1:0]            slot_q;
  logic [GW-1:0]         gcnt_q;
  logic                  in_xfer;
  logic                  out_xfer;

  // Handshake decode and full-flag update (clear before set)
  always_comb begin
    oREADY   = ~iRESET & ~full_q[wp_q];
    oVALID   = full_q[rp_q];
    oLAST    = (gcnt_q == LAST_G);
    in_xfer  = iVALID & oREADY;
    out_xfer = oVALID & iREADY;
    full_d   = full_q;
    if (out_xfer) begin
      full_d[rp_q] = 1'b0;
    end
    if (in_xfer && (slot_q == SLOT_MAX)) begin
      full_d[wp_q] = 1'b1;
    end
  end

  // Bank storage, pointers and frame group counter
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 4; s++) begin
          re_q[b][s] <= '0;
          im_q[b][s] <= '0;
        end
      end
      full_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      slot_q <= '0;
      gcnt_q <= '0;
    end else begin
      full_q <= full_d;
      if (in_xfer) begin
        re_q[wp_q][slot_q] <= iRE;
        im_q[wp_q][slot_q] <= iIM;
        // slot wraps 3 -> 0 on its own; the bank switches with it
        slot_q <= slot_q + 2'd1;
        if (slot_q == SLOT_MAX) begin
          wp_q <= ~wp_q;
        end
      end
      if (out_xfer) begin
        rp_q   <= ~rp_q;
        gcnt_q <= (gcnt_q == LAST_G) ? '0 : gcnt_q + GW'(1);
      end
    end
  end

  // Present the read bank in output order
  always_comb begin
    oX0_RE = re_q[rp_q][SLOT_X0];
    oX0_IM = im_q[rp_q][SLOT_X0];
    oX1_RE = re_q[rp_q][SLOT_X1];
    oX1_IM = im_q[rp_q][SLOT_X1];
    oX2_RE = re_q[rp_q][SLOT_X2];
    oX2_IM = im_q[rp_q][SLOT_X2];
    oX3_RE = re_q[rp_q][SLOT_X3];
    oX3_IM = im_q[rp_q][SLOT_X3];
  end

endmodule
